// File: rtl/divider_pkg.sv
// Shared definitions for the iterative restoring divider.
// Provides the FSM state type, the datapath width, the iteration count and
// the quotient value reported on a zero divisor.
package divider_pkg;

   localparam int DIV_WIDTH      = 32;
   localparam int DIV_ITERATIONS = 32;

   localparam logic [DIV_WIDTH-1:0] DIV_BY_ZERO_QUOTIENT = 32'hFFFFFFFF;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PREP,
      S_DIVIDE,
      S_FIXUP,
      S_DONE
   } div_state_t;

endpackage : divider_pkg

// File: rtl/carry_lookahead_adder.sv
// 32-bit adder built from eight 4-bit carry-lookahead groups chained by
// their group carries.
// Ports:
//   a_i, b_i   : addends
//   carry_i    : carry into bit 0
//   sum_o      : a_i + b_i + carry_i (low 32 bits)
//   carry_o    : carry out of bit 31
module carry_lookahead_adder (
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  logic        carry_i,
   output logic [31:0] sum_o,
   output logic        carry_o
);

   always_comb begin : cla
      logic [31:0] g;
      logic [31:0] p;
      logic [32:0] c;
      g = a_i & b_i;
      p = a_i ^ b_i;
      c = '0;
      c[0] = carry_i;
      for (int k = 0; k < 8; k++) begin
         // Every carry inside a group is taken from the group's carry-in,
         // so only the group carries ripple.
         c[4*k+1] = g[4*k] | (p[4*k] & c[4*k]);
         c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])
                  | (p[4*k+1] & p[4*k] & c[4*k]);
         c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
                  | (p[4*k+2] & p[4*k+1] & g[4*k])
                  | (p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
         c[4*k+4] = g[4*k+3] | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
      end
      sum_o   = p ^ c[31:0];
      carry_o = c[32];
   end

endmodule : carry_lookahead_adder

// File: rtl/fractionned_divider.sv
// Iterative 32-bit signed/unsigned divider, one quotient bit per clock by
// restoring shift-subtract. Divide-by-zero and signed overflow finish early.
// Handshake: the requester raises enable and holds it; output_valid rises
// once results are stable and stays high while enable is held. Dropping
// enable returns the unit to idle (aborting any operation in flight);
// quotient/remainder keep their last values.
// Ports:
//   clock, reset        : rising-edge clock, asynchronous active-high reset
//   input_a / input_b   : dividend / divisor, latched when a request starts
//   signed_a / signed_b : operand is two's complement
//   enable              : level-held request
//   output_quotient     : quotient (rounded toward zero)
//   output_remainder    : remainder, sign follows the dividend
//   output_div_by_zero  : result came from the zero-divisor path
//   output_valid        : results valid
//   debug_state         : current FSM state
module fractionned_divider
   import divider_pkg::*;
(
   input  logic             clock,
   input  logic             reset,
   input  logic [31:0]      input_a,
   input  logic [31:0]      input_b,
   input  logic             signed_a,
   input  logic             signed_b,
   input  logic             enable,
   output logic [31:0]      output_quotient,
   output logic [31:0]      output_remainder,
   output logic             output_div_by_zero,
   output logic             output_valid,
   output div_state_t       debug_state
);

   localparam logic [4:0] LAST_ITER = 5'(DIV_ITERATIONS - 1);

   div_state_t             state_q, state_d;
   logic [DIV_WIDTH-1:0]   a_q, a_d, b_q, b_d;
   logic                   sa_q, sa_d, sb_q, sb_d;
   // Partial remainder. R'[32] always forces a successful subtraction, so
   // the stored remainder never needs a 33rd bit.
   logic [DIV_WIDTH-1:0]   rem_q, rem_d;
   // Dividend magnitude shifting out at the top, quotient bits in at the bottom.
   logic [DIV_WIDTH-1:0]   shift_q, shift_d;
   logic [4:0]             cnt_q, cnt_d;
   logic [DIV_WIDTH-1:0]   quot_q, quot_d, remo_q, remo_d;
   logic                   dbz_q, dbz_d;

   logic                   neg_a, neg_b, overflow, success, trial_cout;
   logic [DIV_WIDTH-1:0]   mag_a, mag_b, trial;
   logic [DIV_WIDTH:0]     rem_shift;

   assign neg_a     = sa_q & a_q[31];
   assign neg_b     = sb_q & b_q[31];
   assign mag_a     = neg_a ? (~a_q + 32'd1) : a_q;
   assign mag_b     = neg_b ? (~b_q + 32'd1) : b_q;
   assign overflow  = sa_q & sb_q & (a_q == 32'h80000000) & (b_q == 32'hFFFFFFFF);
   assign rem_shift = {rem_q, shift_q[31]};

   // R'[31:0] - |b| as R'[31:0] + ~|b| + 1.
   carry_lookahead_adder u_trial (
      .a_i     (rem_shift[31:0]),
      .b_i     (~mag_b),
      .carry_i (1'b1),
      .sum_o   (trial),
      .carry_o (trial_cout)
   );

   assign success = trial_cout | rem_shift[32];

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      rem_d   = rem_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;
      quot_d  = quot_q;
      remo_d  = remo_q;
      dbz_d   = dbz_q;
      case (state_q)
         S_IDLE: begin
            if (enable) begin
               a_d     = input_a;
               b_d     = input_b;
               sa_d    = signed_a;
               sb_d    = signed_b;
               state_d = S_PREP;
            end
         end
         S_PREP: begin
            if (!enable) begin
               state_d = S_IDLE;
            end else if (b_q == '0) begin
               quot_d  = DIV_BY_ZERO_QUOTIENT;
               remo_d  = a_q;
               dbz_d   = 1'b1;
               state_d = S_DONE;
            end else if (overflow) begin
               quot_d  = 32'h80000000;
               remo_d  = '0;
               dbz_d   = 1'b0;
               state_d = S_DONE;
            end else begin
               rem_d   = '0;
               shift_d = mag_a;
               cnt_d   = '0;
               state_d = S_DIVIDE;
            end
         end
         S_DIVIDE: begin
            if (!enable) begin
               state_d = S_IDLE;
            end else begin
               rem_d   = success ? trial : rem_shift[31:0];
               shift_d = {shift_q[30:0], success};
               cnt_d   = cnt_q + 5'd1;
               if (cnt_q == LAST_ITER) state_d = S_FIXUP;
            end
         end
         S_FIXUP: begin
            if (!enable) begin
               state_d = S_IDLE;
            end else begin
               quot_d  = (neg_a ^ neg_b) ? (~shift_q + 32'd1) : shift_q;
               remo_d  = neg_a ? (~rem_q + 32'd1) : rem_q;
               dbz_d   = 1'b0;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (!enable) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         rem_q   <= '0;
         shift_q <= '0;
         cnt_q   <= '0;
         quot_q  <= '0;
         remo_q  <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         rem_q   <= rem_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         quot_q  <= quot_d;
         remo_q  <= remo_d;
         dbz_q   <= dbz_d;
      end
   end

   assign output_quotient    = quot_q;
   assign output_remainder   = remo_q;
   assign output_div_by_zero = dbz_q;
   assign output_valid       = (state_q == S_DONE);
   assign debug_state        = state_q;

endmodule : fractionned_divider

// File: tb/tb_fractionned_divider.sv
module tb_fractionned_divider;
   import divider_pkg::*;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] input_a, input_b;
   logic        signed_a, signed_b, enable;
   logic [31:0] output_quotient, output_remainder;
   logic        output_div_by_zero, output_valid;
   div_state_t  debug_state;

   int n_vec = 0;
   int n_err = 0;
   logic [31:0] exp_q[$];

   fractionned_divider dut (
      .clock              (clock),
      .reset              (reset),
      .input_a            (input_a),
      .input_b            (input_b),
      .signed_a           (signed_a),
      .signed_b           (signed_b),
      .enable             (enable),
      .output_quotient    (output_quotient),
      .output_remainder   (output_remainder),
      .output_div_by_zero (output_div_by_zero),
      .output_valid       (output_valid),
      .debug_state        (debug_state)
   );

   // ---- clock / reset ----
   always #5 clock = ~clock;

   // ---- checker ----
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // ---- reference model: integer arithmetic on sign-extended operands ----
   task automatic model(input logic [31:0] a, input logic [31:0] b,
                        input logic sa, input logic sb,
                        output logic [31:0] q, output logic [31:0] r,
                        output logic dbz, output int lat);
      longint va, vb;
      dbz = 1'b0;
      lat = 35;
      if (b == 32'd0) begin
         q = 32'hFFFFFFFF; r = a; dbz = 1'b1; lat = 2;
      end else if (sa && sb && a == 32'h80000000 && b == 32'hFFFFFFFF) begin
         q = 32'h80000000; r = 32'd0; lat = 2;
      end else begin
         va = sa ? {{32{a[31]}}, a} : {32'd0, a};
         vb = sb ? {{32{b[31]}}, b} : {32'd0, b};
         q = 32'(va / vb);
         r = 32'(va % vb);
      end
   endtask

   // ---- driver: one full request / release transaction ----
   task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                          input logic sa, input logic sb, input string tag);
      logic [31:0] eq, er;
      logic        edbz;
      int          elat, edges;
      bit          seen;
      model(a, b, sa, sb, eq, er, edbz, elat);
      exp_q.push_back(eq);
      exp_q.push_back(er);
      @(negedge clock);
      input_a = a; input_b = b; signed_a = sa; signed_b = sb; enable = 1'b1;
      edges = 0;
      seen  = 0;
      while (!seen && edges < 100) begin
         @(posedge clock);
         edges++;
         @(negedge clock);
         // operands must be ignored once latched
         input_a = $urandom; input_b = $urandom;
         signed_a = 1'($urandom); signed_b = 1'($urandom);
         if (output_valid) seen = 1;
      end
      check({tag, " latency"}, 32'(edges), 32'(elat));
      check({tag, " quotient"}, output_quotient, exp_q.pop_front());
      check({tag, " remainder"}, output_remainder, exp_q.pop_front());
      check({tag, " div_by_zero"}, {31'd0, output_div_by_zero}, {31'd0, edbz});
      // held while enable stays high
      @(negedge clock);
      check({tag, " valid held"}, {31'd0, output_valid}, 32'd1);
      enable = 1'b0;
      @(negedge clock);
      check({tag, " valid drop"}, {31'd0, output_valid}, 32'd0);
      check({tag, " quotient kept"}, output_quotient, eq);
   endtask

   initial begin
      logic [31:0] ra, rb;
      logic        rsa, rsb;
      reset = 1'b1; enable = 1'b0;
      input_a = '0; input_b = '0; signed_a = 1'b0; signed_b = 1'b0;
      #1;
      check("reset quotient", output_quotient, 32'd0);
      check("reset remainder", output_remainder, 32'd0);
      check("reset dbz", {31'd0, output_div_by_zero}, 32'd0);
      check("reset valid", {31'd0, output_valid}, 32'd0);
      check("reset state", 32'(debug_state), 32'(S_IDLE));
      repeat (2) @(negedge clock);
      reset = 1'b0;

      // directed cases
      run_div(32'd100, 32'd7, 1'b0, 1'b0, "u100/7");
      run_div(32'hFFFFFFF9, 32'd2, 1'b1, 1'b1, "s-7/2");
      run_div(32'hFFFFFFFF, 32'd1, 1'b0, 1'b0, "uFFFFFFFF/1");
      run_div(32'd5, 32'd0, 1'b0, 1'b0, "u5/0");
      run_div(32'd5, 32'd0, 1'b1, 1'b1, "s5/0");
      run_div(32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b1, "s_ovf");
      run_div(32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, "u_ovf_operands");
      run_div(32'h80000000, 32'd3, 1'b1, 1'b0, "mixed_sign");

      // abort during iteration
      @(negedge clock);
      input_a = 32'd12345; input_b = 32'd17; signed_a = 1'b0; signed_b = 1'b0;
      enable = 1'b1;
      repeat (11) @(negedge clock);
      check("abort mid state", 32'(debug_state), 32'(S_DIVIDE));
      enable = 1'b0;
      @(negedge clock);
      check("abort state", 32'(debug_state), 32'(S_IDLE));
      for (int i = 0; i < 3; i++) begin
         check("abort valid", {31'd0, output_valid}, 32'd0);
         @(negedge clock);
      end
      run_div(32'd1000, 32'd10, 1'b0, 1'b0, "after_abort");

      // asynchronous reset mid-divide
      @(negedge clock);
      input_a = 32'd99999; input_b = 32'd3; signed_a = 1'b0; signed_b = 1'b0;
      enable = 1'b1;
      repeat (15) @(posedge clock);
      #2 reset = 1'b1;
      #1;
      check("async quotient", output_quotient, 32'd0);
      check("async remainder", output_remainder, 32'd0);
      check("async valid", {31'd0, output_valid}, 32'd0);
      check("async state", 32'(debug_state), 32'(S_IDLE));
      enable = 1'b0;
      @(negedge clock);
      reset = 1'b0;
      run_div(32'hFFFFFFFF, 32'h00010000, 1'b0, 1'b0, "after_reset");

      // randomized
      for (int i = 0; i < 40; i++) begin
         ra  = $urandom;
         rsa = 1'($urandom);
         rsb = 1'($urandom);
         case ($urandom_range(0, 5))
            0: rb = 32'd0;
            1: rb = 32'($urandom_range(1, 255));
            2: begin rb = 32'hFFFFFFFF; ra = 32'h80000000; end
            3: rb = 32'hFFFFFFFF - 32'($urandom_range(0, 15));
            default: rb = $urandom;
         endcase
         run_div(ra, rb, rsa, rsb, "random");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_fractionned_divider
